// File: rtl/azar_source.sv
// Seedable Galois-LFSR source of (a, b, c) triples for the azar NAND-mux stage,
// issued in programmed-length bursts over a valid/ready handshake.
module azar_source #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed,
  input  logic             start,
  input  logic [7:0]       count,
  input  logic             ready,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             valid,
  output logic             busy,
  output logic             done,
  output logic [7:0]       remaining
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] n;
    n = s >> 1;
    if (s[0]) begin
      n = n ^ TAPS;
    end else begin
      n = n;
    end
    return n;
  endfunction

  logic [0:0]       state_r, state_s;
  logic [WIDTH-1:0] lfsr_r, lfsr_s;
  logic             a_r, b_r, c_r, a_s, b_s, c_s;
  logic             valid_r, valid_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [7:0]       remaining_r, remaining_s;
  logic [WIDTH-1:0] seed_fix_s;
  logic [WIDTH-1:0] idle_state_s;

  // An all-zero seed would lock the LFSR, so it is replaced by the default.
  assign seed_fix_s   = (seed == {WIDTH{1'b0}}) ? DEFAULT_SEED : seed;
  assign idle_state_s = seed_load ? seed_fix_s : lfsr_r;

  // Next-state and next-output computation for the burst FSM.
  always_comb begin
    state_s     = state_r;
    lfsr_s      = lfsr_r;
    a_s         = a_r;
    b_s         = b_r;
    c_s         = c_r;
    valid_s     = valid_r;
    busy_s      = busy_r;
    remaining_s = remaining_r;
    done_s      = 1'b0;
    case (state_r)
      ST_IDLE: begin
        lfsr_s = idle_state_s;
        if (start && (count != 8'd0)) begin
          a_s         = idle_state_s[0];
          b_s         = idle_state_s[1];
          c_s         = idle_state_s[2];
          lfsr_s      = lfsr_step(idle_state_s);
          valid_s     = 1'b1;
          busy_s      = 1'b1;
          remaining_s = count;
          state_s     = ST_RUN;
        end else if (start) begin
          done_s = 1'b1;
        end else begin
          done_s = 1'b0;
        end
      end
      ST_RUN: begin
        if (valid_r && ready) begin
          if (remaining_r > 8'd1) begin
            a_s         = lfsr_r[0];
            b_s         = lfsr_r[1];
            c_s         = lfsr_r[2];
            lfsr_s      = lfsr_step(lfsr_r);
            remaining_s = remaining_r - 8'd1;
          end else begin
            valid_s     = 1'b0;
            busy_s      = 1'b0;
            remaining_s = 8'd0;
            done_s      = 1'b1;
            state_s     = ST_IDLE;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      default: begin
        valid_s     = 1'b0;
        busy_s      = 1'b0;
        remaining_s = 8'd0;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State, LFSR and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      lfsr_r      <= DEFAULT_SEED;
      a_r         <= 1'b0;
      b_r         <= 1'b0;
      c_r         <= 1'b0;
      valid_r     <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      remaining_r <= 8'd0;
    end else begin
      state_r     <= state_s;
      lfsr_r      <= lfsr_s;
      a_r         <= a_s;
      b_r         <= b_s;
      c_r         <= c_s;
      valid_r     <= valid_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
      remaining_r <= remaining_s;
    end
  end

  assign a         = a_r;
  assign b         = b_r;
  assign c         = c_r;
  assign valid     = valid_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign remaining = remaining_r;

endmodule

// File: tb/tb_azar_source.sv
// Scoreboard bench for azar_source: a command observer expands each accepted
// burst into expected triples; the monitor compares every cycle against them.
module tb_azar_source;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        seed_load = 1'b0;
  logic [15:0] seed = 16'd0;
  logic        start = 1'b0;
  logic [7:0]  count = 8'd0;
  logic        ready = 1'b1;
  logic        a, b, c, valid, busy, done;
  logic [7:0]  remaining;

  int checks = 0;
  int errors = 0;

  logic [2:0]  exp_q[$];
  logic [2:0]  seen[$];
  logic        exp_valid = 1'b0;
  logic        exp_done = 1'b0;
  logic [15:0] model = 16'hACE1;

  localparam logic [2:0] TBL [6] = '{3'b100, 3'b000, 3'b000, 3'b001, 3'b011, 3'b111};

  azar_source dut (
    .clk(clk), .rst_n(rst_n), .seed_load(seed_load), .seed(seed),
    .start(start), .count(count), .ready(ready),
    .a(a), .b(b), .c(c), .valid(valid), .busy(busy), .done(done),
    .remaining(remaining)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] next_state(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare this cycle's outputs, then advance the reference model.
  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_outputs", 32'({a, b, c, valid, busy, done, remaining}), 32'd0);
      exp_q.delete();
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      model     = 16'hACE1;
    end else begin
      check("valid", 32'(valid), 32'(exp_valid));
      check("busy", 32'(busy), 32'(exp_valid));
      check("done", 32'(done), 32'(exp_done));
      if (exp_valid) begin
        check("triple", 32'({a, b, c}), 32'(exp_q[0]));
        check("remaining", 32'(remaining), 32'(exp_q.size()));
      end else begin
        check("remaining_idle", 32'(remaining), 32'd0);
      end
      if (valid && ready) seen.push_back({a, b, c});
      exp_done = 1'b0;
      if (exp_valid) begin
        if (ready) begin
          void'(exp_q.pop_front());
          if (exp_q.size() == 0) begin
            exp_valid = 1'b0;
            exp_done  = 1'b1;
          end
        end
      end else begin
        if (seed_load) model = (seed == 16'd0) ? 16'hACE1 : seed;
        if (start) begin
          if (count == 8'd0) begin
            exp_done = 1'b1;
          end else begin
            for (int i = 0; i < int'(count); i++) begin
              exp_q.push_back({model[0], model[1], model[2]});
              model = next_state(model);
            end
            exp_valid = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] n);
    start = 1'b1;
    count = n;
    tick();
    start = 1'b0;
    count = 8'd0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 300) begin
      tick();
      k++;
    end
    if (k >= 300) check("wait_idle_timeout", 32'd1, 32'd0);
    tick();
  endtask

  task automatic do_reset();
    start = 1'b0;
    seed_load = 1'b0;
    ready = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    seen.delete();
  endtask

  task automatic check_seen(input string name, input int first, input int n);
    check({name, "_count"}, 32'(seen.size()), 32'(n));
    for (int k = 0; k < n && k < seen.size(); k++)
      check(name, 32'(seen[k]), 32'(TBL[first + k]));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

  initial begin
    #2;
    do_reset();

    // Reset then full burst with ready held high.
    issue(8'd6);
    wait_idle();
    check_seen("burst6", 0, 6);

    // Backpressure after the second triple.
    do_reset();
    issue(8'd6);
    tick();
    tick();
    ready = 1'b0;
    repeat (3) tick();
    ready = 1'b1;
    wait_idle();
    check_seen("backpressure", 0, 6);

    // Zero seed replaced by default, then seed loaded together with start.
    seen.delete();
    seed = 16'd0;
    seed_load = 1'b1;
    tick();
    seed_load = 1'b0;
    issue(8'd1);
    wait_idle();
    check_seen("zero_seed", 0, 1);
    seen.delete();
    seed = 16'h0007;
    seed_load = 1'b1;
    issue(8'd1);
    seed_load = 1'b0;
    wait_idle();
    check("seed7_count", 32'(seen.size()), 32'd1);
    if (seen.size() > 0) check("seed7_triple", 32'(seen[0]), 32'(3'b111));

    // Zero count, then commands during RUN that must be ignored.
    issue(8'd0);
    tick();
    issue(8'd4);
    start = 1'b1;
    count = 8'd9;
    seed_load = 1'b1;
    seed = 16'h1234;
    repeat (2) tick();
    start = 1'b0;
    seed_load = 1'b0;
    wait_idle();

    // Continuity across two bursts.
    do_reset();
    issue(8'd3);
    wait_idle();
    issue(8'd3);
    wait_idle();
    check_seen("continuity", 0, 6);

    // Asynchronous reset mid-burst.
    do_reset();
    issue(8'd6);
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 32'({a, b, c, valid, busy, done, remaining}), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    seen.delete();
    issue(8'd1);
    wait_idle();
    check_seen("after_async", 0, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      ready     = ($urandom_range(0, 9) < 7);
      start     = ($urandom_range(0, 5) == 0);
      count     = 8'($urandom_range(0, 10));
      seed_load = ($urandom_range(0, 15) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 16'd0 : 16'($urandom);
      tick();
    end
    start = 1'b0;
    seed_load = 1'b0;
    ready = 1'b1;
    wait_idle();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/azar_source.md
# azar_source

Pseudo-random stimulus source for the `azar` 2:1 NAND-mux stage: it produces the select/data triple `a`, `b`, `c` that the mux stage consumes (f = a ? b : c). Triples come from a Galois LFSR and are issued in bursts of a programmed length over a valid/ready handshake. The sequence is seedable, so a bench or on-board checker can predict every triple and the resulting `f`.

## Interface
Parameters:
- `WIDTH`, 16: LFSR width, minimum 3.
- `TAPS`, 16'hB400: Galois feedback mask, XORed into the state when the shifted-out LSB is 1.
- `DEFAULT_SEED`, 16'hACE1: reset state, and the replacement for any all-zero seed.

Ports:
- `clk` input 1: single clock; everything is rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `seed_load` input 1: load `seed` into the LFSR. Honoured in IDLE only.
- `seed` input WIDTH: seed value.
- `start` input 1: begin a burst. Honoured in IDLE only.
- `count` input 8: burst length in triples, sampled with `start`.
- `ready` input 1: downstream accepts the current triple.
- `a`, `b`, `c` output 1 each: current triple.
- `valid` output 1: triple on `a`/`b`/`c` is valid.
- `busy` output 1: high in RUN.
- `done` output 1: one-cycle pulse at burst end.
- `remaining` output 8: triples not yet accepted, including the one being presented.

## Operation
- **LFSR step:** `lsb = s[0]; s_next = s >> 1; if (lsb) s_next ^= TAPS`.
- **Triple extraction:** taken from the LFSR state *before* the step: `a = s[0]`, `b = s[1]`, `c = s[2]`. Every issued triple advances the LFSR by exactly one step.
- **FSM states:** IDLE, RUN.
- **IDLE + `seed_load`:** LFSR loads `seed`, or `DEFAULT_SEED` if `seed == 0`.
- **IDLE + `start` with `count != 0`:**
  - The output register loads the triple from the effective state. If `seed_load` is asserted in the same cycle, the effective state is the new seed.
  - LFSR steps; `valid` = 1, `remaining` = `count`, `busy` = 1; go to RUN.
- **IDLE + `start` with `count == 0`:** no triple is issued; `done` pulses next cycle; stay in IDLE.
- **RUN, `valid && ready`, `remaining > 1`:** load the next triple from the current LFSR state, step the LFSR, decrement `remaining`. `valid` stays high, giving back-to-back transfers.
- **RUN, `valid && ready`, `remaining == 1`:** `valid` = 0, `remaining` = 0, `busy` = 0, `done` pulses; return to IDLE. The LFSR does not step.
- **RUN, `ready` low:** `a`, `b`, `c`, `valid`, `remaining` and the LFSR all hold.
- **RUN, `start` or `seed_load`:** ignored.
- **Sequence continuity:** the LFSR state persists across bursts. A second burst continues the sequence unless it is reseeded.

## Timing
- **Reset values:** LFSR = `DEFAULT_SEED`, state = IDLE; `a` = `b` = `c` = 0, `valid` = 0, `busy` = 0, `done` = 0, `remaining` = 0.
- **Reset mid-burst:** `rst_n` low at any time forces all reset values immediately (asynchronous). There is no partial burst after release.
- **Start latency:** `start` sampled at edge N gives `valid` = 1 after edge N; the first triple is available in cycle N+1.
- **Throughput:** one triple per cycle while `ready` is held high; a burst of K takes K cycles of `valid`.
- **Done timing:** `done` is high for exactly the cycle after the last handshake, coincident with `valid` = 0 and `busy` = 0.
- **Back-to-back bursts:** a new `start` is accepted in the same cycle `done` is high.
- **Output timing:** all outputs are registered, with no combinational path from `ready` to `valid`.

## Test plan
- **Reset then burst:** reset, `start` with `count` = 6, `ready` = 1. Required triples (a,b,c): (1,0,0), (0,0,0), (0,0,0), (0,0,1), (0,1,1), (1,1,1). `remaining` goes 6..1; `done` is high one cycle after the 6th.
- **Backpressure:** same burst with `ready` low for 3 cycles after the 2nd triple. The 3rd triple (0,0,0) and `remaining` = 4 hold for all 3 stalled cycles, and the full sequence matches the first scenario.
- **Reseed and zero seed:**
  - `seed_load` with `seed` = 0, then `start` with `count` = 1 → triple (1,0,0), because the zero seed is replaced by 16'hACE1.
  - `seed` = 16'h0007 with `start` asserted in the same cycle → first triple (1,1,1).
- **Zero count and ignored commands:**
  - `start` with `count` = 0 → no `valid`; `done` pulses once.
  - `start`/`seed_load` issued during RUN → no effect on `remaining` or the sequence.
- **Continuity:** burst of `count` = 3 then burst of `count` = 3, with no reseed between. The second burst yields (0,0,1), (0,1,1), (1,1,1).
- **Async reset mid-burst:** `rst_n` low while `remaining` = 3 → outputs clear without waiting for a clock edge. After release, `start` with `count` = 1 → (1,0,0).
